// File: rtl/usb_pkg.sv
// usb_pkg: shared types and defaults for the USB endpoint transaction sequencer.
// PID encoding matches the packet decoder and the transmitter.
package usb_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 96;
    localparam int BUF_DEPTH_DEF      = 64;

    typedef enum logic [2:0] {
        PID_NONE  = 3'd0,
        PID_OUT   = 3'd1,
        PID_IN    = 3'd2,
        PID_DATA0 = 3'd3,
        PID_DATA1 = 3'd4,
        PID_ACK   = 3'd5,
        PID_NAK   = 3'd6,
        PID_STALL = 3'd7
    } pid_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_TXD  = 3'd3,
        ST_WAIT_HS   = 3'd4,
        ST_HS_TX     = 3'd5
    } state_e;

    // DATA PID that corresponds to a given toggle value
    function automatic pid_e data_pid(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction

    function automatic logic is_data(input pid_e pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// usb_txn_ctrl_if: receive-side, host-side and transmit-side signals of the
// transaction sequencer. The sequencer takes the slave modport; whoever drives
// the receiver/host/transmitter events takes the master modport.
interface usb_txn_ctrl_if;
    import usb_pkg::*;

    pid_e        rx_packet;
    logic        rx_data_ready;
    logic        rx_transfer_active;
    logic        rx_error;
    logic [6:0]  buffer_occupancy;
    logic        host_tx_load;
    logic        host_rx_ack;
    logic        tx_done;

    pid_e        tx_packet;
    logic        tx_start;
    logic        clear;
    logic        rx_data_avail;
    logic        tx_pending;
    logic        data_toggle;
    logic        txn_error;

    modport slave (
        input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
               buffer_occupancy, host_tx_load, host_rx_ack, tx_done,
        output tx_packet, tx_start, clear, rx_data_avail, tx_pending,
               data_toggle, txn_error
    );

    modport master (
        output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
               buffer_occupancy, host_tx_load, host_rx_ack, tx_done,
        input  tx_packet, tx_start, clear, rx_data_avail, tx_pending,
               data_toggle, txn_error
    );

endinterface

// File: rtl/usb_txn_timer.sv
// usb_txn_timer: saturating up-counter used for DATA / handshake timeouts.
// clr holds it at zero; it advances only when en is high and stops at the
// terminal value, where expired stays asserted until cleared.
module usb_txn_timer #(
    parameter int TIMEOUT_CYCLES = 96
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // count up while enabled, saturating at the terminal value
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: USB device endpoint transaction sequencer.
// Watches received packets, chooses the handshake or DATA packet to send back,
// flushes the data buffer, and tracks RX/TX payload ownership with the host.
// Optional feature: define USB_TOGGLE_CHK_EN to treat a DATA PID that does not
// match data_toggle as a host retransmit (ACK + flush, no state change).
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for an OUT or IN token
// ST_WAIT_DATA | OUT seen, waiting for DATA0/DATA1 (timed)
// ST_SEND      | IN answered; tx_start visible this cycle (DATA or NAK)
// ST_WAIT_TXD  | our DATA packet is on the wire, waiting for tx_done
// ST_WAIT_HS   | waiting for the host ACK/NAK on our DATA (timed)
// ST_HS_TX     | our handshake (ACK/NAK) is on the wire, waiting for tx_done
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int BUF_DEPTH      = BUF_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    usb_txn_ctrl_if.slave  bus
);

    state_e state;
    pid_e   tx_packet_q;
    logic   tx_start_q;
    logic   clear_q;
    logic   rx_data_avail_q;
    logic   tx_pending_q;
    logic   data_toggle_q;
    logic   txn_error_q;

    logic   timer_clr;
    logic   timer_expired;
    logic   pkt_valid;
    logic   load_ok;
    logic   avail_eff;
    logic   retransmit;

    assign pkt_valid = bus.rx_data_ready;

    // Host load only counts when there is payload and the buffer is not
    // currently holding OUT data that the host has yet to drain.
    assign load_ok = (bus.buffer_occupancy != '0) &&
                     (bus.buffer_occupancy <= 7'(BUF_DEPTH)) &&
                     !rx_data_avail_q;

    // A host drain in the same cycle as a DATA packet frees the buffer first.
    assign avail_eff = rx_data_avail_q && !bus.host_rx_ack;

`ifdef USB_TOGGLE_CHK_EN
    assign retransmit = (bus.rx_packet != data_pid(data_toggle_q));
`else
    assign retransmit = 1'b0;
`endif

    // Timer only runs in the two waiting states; it is held at zero elsewhere
    // so each wait starts from a fresh count.
    assign timer_clr = !((state == ST_WAIT_DATA) || (state == ST_WAIT_HS));

    usb_txn_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (!bus.rx_transfer_active),
        .expired (timer_expired)
    );

    // sequencer: state, registered pulses and ownership flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            tx_packet_q     <= PID_NONE;
            tx_start_q      <= 1'b0;
            clear_q         <= 1'b0;
            rx_data_avail_q <= 1'b0;
            tx_pending_q    <= 1'b0;
            data_toggle_q   <= 1'b0;
            txn_error_q     <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            tx_packet_q <= PID_NONE;
            clear_q     <= 1'b0;

            if (bus.host_tx_load && load_ok) begin
                tx_pending_q <= 1'b1;
            end
            if (bus.host_rx_ack) begin
                rx_data_avail_q <= 1'b0;
                clear_q         <= 1'b1;
            end

            if (bus.rx_error) begin
                clear_q     <= 1'b1;
                txn_error_q <= 1'b1;
                if (state == ST_WAIT_DATA) begin
                    rx_data_avail_q <= 1'b0;
                end
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pkt_valid && (bus.rx_packet == PID_OUT)) begin
                            state <= ST_WAIT_DATA;
                        end else if (pkt_valid && (bus.rx_packet == PID_IN)) begin
                            state       <= ST_SEND;
                            tx_start_q  <= 1'b1;
                            tx_packet_q <= tx_pending_q ? data_pid(data_toggle_q) : PID_NAK;
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (pkt_valid && is_data(bus.rx_packet)) begin
                            state      <= ST_HS_TX;
                            tx_start_q <= 1'b1;
                            if (retransmit) begin
                                tx_packet_q <= PID_ACK;
                                clear_q     <= 1'b1;
                            end else if (avail_eff) begin
                                tx_packet_q <= PID_NAK;
                            end else begin
                                tx_packet_q     <= PID_ACK;
                                rx_data_avail_q <= 1'b1;
                                data_toggle_q   <= !data_toggle_q;
                            end
                        end else if (timer_expired) begin
                            clear_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                    // tx_packet_q still holds what was launched on entry
                    ST_SEND: begin
                        state <= (tx_packet_q == PID_NAK) ? ST_HS_TX : ST_WAIT_TXD;
                    end
                    ST_WAIT_TXD: begin
                        if (bus.tx_done) begin
                            state <= ST_WAIT_HS;
                        end
                    end
                    ST_WAIT_HS: begin
                        if (pkt_valid && (bus.rx_packet == PID_ACK)) begin
                            clear_q       <= 1'b1;
                            tx_pending_q  <= 1'b0;
                            data_toggle_q <= !data_toggle_q;
                            state         <= ST_IDLE;
                        end else if (pkt_valid && (bus.rx_packet == PID_NAK)) begin
                            state <= ST_IDLE;
                        end else if (timer_expired) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HS_TX: begin
                        if (bus.tx_done) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx_packet     = tx_packet_q;
    assign bus.tx_start      = tx_start_q;
    assign bus.clear         = clear_q;
    assign bus.rx_data_avail = rx_data_avail_q;
    assign bus.tx_pending    = tx_pending_q;
    assign bus.data_toggle   = data_toggle_q;
    assign bus.txn_error     = txn_error_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb_usb_txn_ctrl: directed scenarios followed by a random mix of
// transactions, checked against a transaction-level model of the endpoint
// (ownership flags, toggle, sticky error, count of buffer flushes).
module tb_usb_txn_ctrl;
    import usb_pkg::*;

    localparam int TO = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_txn_ctrl_if ifc ();

    usb_txn_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .BUF_DEPTH      (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_clear = 0;

    // reference model state
    bit m_avail, m_pend, m_tog, m_err;
    int exp_clear = 0;

`ifdef USB_TOGGLE_CHK_EN
    localparam bit TOG_CHK = 1'b1;
`else
    localparam bit TOG_CHK = 1'b0;
`endif

    // count flush pulses as they are seen on the clock edge
    always @(posedge clk) begin
        if (ifc.clear === 1'b1) n_clear++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_pid(input pid_e p);
        ifc.rx_packet     = p;
        ifc.rx_data_ready = 1'b1;
        tick();
        ifc.rx_data_ready = 1'b0;
        ifc.rx_packet     = PID_NONE;
    endtask

    task automatic pulse_done();
        tick(2);
        ifc.tx_done = 1'b1;
        tick();
        ifc.tx_done = 1'b0;
    endtask

    function automatic pid_e exp_data(input bit tog);
        return tog ? PID_DATA1 : PID_DATA0;
    endfunction

    task automatic expect_tx(input string tag, input pid_e p);
        chk({tag, "_start"}, ifc.tx_start, 1);
        chk({tag, "_pid"}, ifc.tx_packet, p);
    endtask

    task automatic check_state(input string tag);
        tick();
        chk({tag, "_avail"}, ifc.rx_data_avail, m_avail);
        chk({tag, "_pend"}, ifc.tx_pending, m_pend);
        chk({tag, "_tog"}, ifc.data_toggle, m_tog);
        chk({tag, "_err"}, ifc.txn_error, m_err);
        chk({tag, "_clears"}, n_clear, exp_clear);
        chk({tag, "_idle_start"}, ifc.tx_start, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        chk("rst_start", ifc.tx_start, 0);
        chk("rst_pid", ifc.tx_packet, PID_NONE);
        chk("rst_clear", ifc.clear, 0);
        chk("rst_flags", {ifc.rx_data_avail, ifc.tx_pending, ifc.data_toggle, ifc.txn_error}, 0);
        rst = 1'b0;
        m_avail = 0; m_pend = 0; m_tog = 0; m_err = 0;
        check_state("rst");
    endtask

    task automatic host_load(input int occ);
        ifc.buffer_occupancy = 7'(occ);
        ifc.host_tx_load = 1'b1;
        tick();
        ifc.host_tx_load = 1'b0;
        if (occ != 0 && !m_avail) m_pend = 1;
        check_state("load");
    endtask

    task automatic host_ack();
        ifc.host_rx_ack = 1'b1;
        tick();
        ifc.host_rx_ack = 1'b0;
        m_avail = 0;
        exp_clear++;
        check_state("hack");
    endtask

    task automatic do_out_data(input pid_e dp, input bit with_ack);
        pid_e ep;
        bit   flush;
        pulse_pid(PID_OUT);
        tick($urandom_range(0, 3));
        ifc.host_rx_ack = with_ack;
        pulse_pid(dp);
        ifc.host_rx_ack = 1'b0;
        flush = with_ack;
        if (with_ack) m_avail = 0;
        if (TOG_CHK && dp != exp_data(m_tog)) begin
            ep = PID_ACK;
            flush = 1;
        end else if (m_avail) begin
            ep = PID_NAK;
        end else begin
            ep = PID_ACK;
            m_avail = 1;
            m_tog = ~m_tog;
        end
        if (flush) exp_clear++;
        expect_tx("out", ep);
        pulse_done();
        check_state("out");
    endtask

    // hs: 0 host ACKs, 1 host NAKs, 2 host stays silent
    task automatic do_in(input int hs);
        pulse_pid(PID_IN);
        if (!m_pend) begin
            expect_tx("in_nak", PID_NAK);
            pulse_done();
        end else begin
            expect_tx("in_data", exp_data(m_tog));
            pulse_done();
            tick();
            case (hs)
                0: begin
                    pulse_pid(PID_ACK);
                    m_pend = 0;
                    m_tog = ~m_tog;
                    exp_clear++;
                end
                1: pulse_pid(PID_NAK);
                default: tick(TO + 5);
            endcase
        end
        check_state("in");
    endtask

    task automatic out_timeout();
        int k;
        int n;
        bit seen;
        pulse_pid(PID_OUT);
        k = $urandom_range(0, 5);
        ifc.rx_transfer_active = 1'b1;
        tick(k);
        ifc.rx_transfer_active = 1'b0;
        n = k;
        seen = 1'b0;
        while (!seen && n < TO + 40) begin
            tick();
            n++;
            seen = ifc.clear;
        end
        chk("out_timeout_cycles", n, TO + k);
        exp_clear++;
        check_state("oto");
    endtask

    task automatic rx_err_in_wait();
        pulse_pid(PID_OUT);
        tick($urandom_range(0, 3));
        ifc.rx_error = 1'b1;
        tick();
        ifc.rx_error = 1'b0;
        chk("err_no_tx", ifc.tx_start, 0);
        m_err = 1;
        m_avail = 0;
        exp_clear++;
        check_state("rxerr");
    endtask

    task automatic reset_mid_txn();
        if ($urandom_range(0, 1) != 0) pulse_pid(PID_OUT);
        else pulse_pid(PID_IN);
        do_reset();
    endtask

    initial begin
        ifc.rx_packet          = PID_NONE;
        ifc.rx_data_ready      = 1'b0;
        ifc.rx_transfer_active = 1'b0;
        ifc.rx_error           = 1'b0;
        ifc.buffer_occupancy   = 7'd8;
        ifc.host_tx_load       = 1'b0;
        ifc.host_rx_ack        = 1'b0;
        ifc.tx_done            = 1'b0;
        tick(3);
        do_reset();

        // OUT + DATA0 accepted, then second OUT NAKed while host owns buffer
        do_out_data(PID_DATA0, 1'b0);
        chk("t1_avail", ifc.rx_data_avail, 1);
        chk("t1_tog", ifc.data_toggle, 1);
        do_out_data(PID_DATA1, 1'b0);
        host_ack();
        chk("t2_avail", ifc.rx_data_avail, 0);

        // IN path: DATA0, ACK; NAK when idle; silent host keeps payload
        do_reset();
        host_load(4);
        do_in(0);
        chk("t3_pend", ifc.tx_pending, 0);
        chk("t3_tog", ifc.data_toggle, 1);
        do_in(0);
        host_load(5);
        do_in(2);
        chk("t4_pend_kept", ifc.tx_pending, 1);
        do_in(1);
        do_in(0);

        // errors, timeouts, simultaneous drain + DATA, reset aborts
        rx_err_in_wait();
        chk("t5_err", ifc.txn_error, 1);
        out_timeout();
        do_out_data(PID_DATA0, 1'b0);
        do_out_data(PID_DATA1, 1'b1);
        reset_mid_txn();

`ifdef USB_TOGGLE_CHK_EN
        do_out_data(PID_DATA0, 1'b0);
        host_ack();
        do_out_data(PID_DATA0, 1'b0);
        chk("t6_avail", ifc.rx_data_avail, 0);
        chk("t6_tog", ifc.data_toggle, 1);
`endif

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1: do_out_data($urandom_range(0, 1) != 0 ? PID_DATA1 : PID_DATA0,
                                  $urandom_range(0, 3) == 0);
                2, 3: do_in($urandom_range(0, 2) == 2 ? 2 : int'($urandom_range(0, 1)));
                4, 5: host_load($urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 64)));
                6:    host_ack();
                7:    rx_err_in_wait();
                8:    if ($urandom_range(0, 3) == 0) out_timeout(); else host_ack();
                default: reset_mid_txn();
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
